// File: rtl/serv_state_w_pkg.sv
// Shared definitions for the W-bit serial sequencing controller:
// state encoding and counter limit helper.
package serv_state_w_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    TRAP = 2'd3
  } state_e;

  // Bit index of the last beat in a 32-bit phase when stepping W bits per beat.
  function automatic logic [4:0] cnt_last(input int w);
    return 5'(32 - w);
  endfunction

endpackage

// File: rtl/serv_state_w_cnt.sv
// W-stepped operand position counter; o_cnt_done flags the final beat of a phase.
module serv_state_w_cnt
  import serv_state_w_pkg::*;
#(
  parameter int W = 1
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_cnt_en,
  output logic [4:0] o_cnt,
  output logic       o_cnt_done,
  output logic       o_cnt0to3,
  output logic       o_cnt12to31
);

  localparam logic [4:0] STEP     = 5'(W);
  localparam logic [4:0] CNT_LAST = cnt_last(W);

  logic [4:0] cnt_r;
  logic       cnt_done_r;
  logic [4:0] cnt_inc_s;

  assign cnt_inc_s = cnt_r + STEP;

  // Advance by W per beat; done is precomputed so it lines up with the last beat.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      cnt_r      <= 5'd0;
      cnt_done_r <= 1'b0;
    end else begin
      if (i_cnt_en) begin
        cnt_r <= cnt_inc_s;
      end else begin
        cnt_r <= cnt_r;
      end
      cnt_done_r <= i_cnt_en & (cnt_inc_s == CNT_LAST);
    end
  end

  assign o_cnt       = cnt_r;
  assign o_cnt_done  = cnt_done_r;
  assign o_cnt0to3   = i_cnt_en & (cnt_r < 5'd4);
  assign o_cnt12to31 = i_cnt_en & (cnt_r >= 5'd12);

endmodule

// File: rtl/serv_state_w.sv
// Sequencing controller for the W-bit serial core: IDLE/INIT/RUN/TRAP FSM,
// interrupt pending, jump latch, dbus request and optional MDU handshake.
module serv_state_w
  import serv_state_w_pkg::*;
#(
  parameter int W   = 1,
  parameter bit MDU = 1'b0
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_new_irq,
  input  logic       i_rf_ready,
  input  logic       i_two_stage_op,
  input  logic       i_shift_op,
  input  logic       i_mem_op,
  input  logic       i_e_op,
  input  logic       i_mdu_op,
  input  logic       i_take_branch,
  input  logic       i_ctrl_misalign,
  input  logic       i_mem_misalign,
  input  logic       i_sh_done,
  input  logic       i_dbus_ack,
  input  logic       i_mdu_ready,
  output logic       o_init,
  output logic       o_cnt_en,
  output logic [4:0] o_cnt,
  output logic       o_cnt_done,
  output logic       o_cnt0to3,
  output logic       o_cnt12to31,
  output logic       o_ctrl_pc_en,
  output logic       o_ctrl_jump,
  output logic       o_ctrl_trap,
  output logic       o_rf_rs_en,
  output logic       o_bufreg_hold,
  output logic       o_dbus_cyc,
  output logic       o_mdu_valid
);

  localparam logic MDU_EN = MDU;

  state_e state_r;
  state_e state_nxt_s;
  logic   stage_one_done_r;
  logic   pending_irq_r;
  logic   ctrl_jump_r;
  logic   bufreg_hold_r;
  logic   bufreg_hold_nxt_s;
  logic   complete_s;
  logic   init_trap_s;
  logic   init_hold_s;

  serv_state_w_cnt #(.W(W)) u_cnt (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_cnt_en    (o_cnt_en),
    .o_cnt       (o_cnt),
    .o_cnt_done  (o_cnt_done),
    .o_cnt0to3   (o_cnt0to3),
    .o_cnt12to31 (o_cnt12to31)
  );

  // Second-stage completion events that release IDLE into RUN.
  assign complete_s  = (i_shift_op & i_sh_done) | (i_mem_op & i_dbus_ack) |
                       (MDU_EN & i_mdu_op & i_mdu_ready);
  assign init_trap_s = (i_mem_op & i_mem_misalign) | (i_take_branch & i_ctrl_misalign);
  assign init_hold_s = i_mem_op | i_shift_op | (MDU_EN & i_mdu_op);

  // Next-state selection; phases only end on the last counter beat.
  always_comb begin
    state_nxt_s       = state_r;
    bufreg_hold_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_rf_ready) begin
          if (i_e_op | pending_irq_r) begin
            state_nxt_s = TRAP;
          end else if (i_two_stage_op & ~stage_one_done_r) begin
            state_nxt_s = INIT;
          end else begin
            state_nxt_s = RUN;
          end
        end else if (stage_one_done_r & complete_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      INIT: begin
        if (!o_cnt_done) begin
          state_nxt_s = INIT;
        end else if (init_trap_s) begin
          state_nxt_s = TRAP;
        end else if (init_hold_s) begin
          state_nxt_s       = IDLE;
          bufreg_hold_nxt_s = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      RUN, TRAP: begin
        if (o_cnt_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, stage tracking, interrupt pending and jump latch registers.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r          <= IDLE;
      stage_one_done_r <= 1'b0;
      pending_irq_r    <= 1'b0;
      ctrl_jump_r      <= 1'b0;
      bufreg_hold_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      bufreg_hold_r <= bufreg_hold_nxt_s;
      // A new request on the trap clear cycle must survive.
      pending_irq_r <= i_new_irq | (pending_irq_r & (state_r != TRAP));
      if (state_r == INIT) begin
        stage_one_done_r <= 1'b1;
      end else if (state_r == RUN) begin
        stage_one_done_r <= 1'b0;
      end else begin
        stage_one_done_r <= stage_one_done_r;
      end
      if (state_r == INIT) begin
        ctrl_jump_r <= i_take_branch;
      end else begin
        ctrl_jump_r <= ctrl_jump_r;
      end
    end
  end

  assign o_init        = (state_r == INIT);
  assign o_cnt_en      = (state_r != IDLE);
  assign o_ctrl_pc_en  = (state_r == RUN) | (state_r == TRAP);
  assign o_ctrl_trap   = (state_r == TRAP);
  assign o_ctrl_jump   = ctrl_jump_r & (state_r != IDLE);
  assign o_rf_rs_en    = i_two_stage_op ? o_init : o_ctrl_pc_en;
  assign o_bufreg_hold = bufreg_hold_r;
  assign o_dbus_cyc    = (state_r == IDLE) & stage_one_done_r & i_mem_op & ~i_mem_misalign;
  assign o_mdu_valid   = (state_r == IDLE) & stage_one_done_r & i_mdu_op & MDU_EN;

endmodule

// File: doc/serv_state_w.md
Name: serv_state_w

Overview:
- Parametrised sequencing controller for the bit-serial core, generalised from 1 bit/cycle to W bits/cycle.
- Owns the IDLE/INIT/RUN/TRAP state machine, the operand position counter, interrupt pending, branch/jump latching, the dbus cycle request and an optional MDU handshake.
- Sits between the instruction decoder, which supplies the per-instruction op-class flags, and the datapath (bufreg, ALU, ctrl, CSR, mem_if).

Parameters:
- W, 1, bits processed per cycle; legal values 1, 2, 4, 8; an instruction phase takes 32/W cycles.
- MDU, 0, 1 enables the multiply/divide handshake; when 0, i_mdu_op is ignored and o_mdu_valid is tied to 0.

Ports:
- clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_new_irq  in  1  interrupt request pulse
- i_rf_ready  in  1  register file has operands ready; starts a phase
- i_two_stage_op  in  1  instruction needs an INIT phase (slt, branch/jump, shift, load/store)
- i_shift_op  in  1  shift instruction
- i_mem_op  in  1  load/store instruction
- i_e_op  in  1  ecall/ebreak
- i_mdu_op  in  1  M-extension instruction
- i_take_branch  in  1  branch condition true (valid in INIT)
- i_ctrl_misalign  in  1  jump target misaligned
- i_mem_misalign  in  1  data address misaligned
- i_sh_done  in  1  shifter finished
- i_dbus_ack  in  1  data bus acknowledge
- i_mdu_ready  in  1  MDU result ready
- o_init  out  1  state==INIT
- o_cnt_en  out  1  state!=IDLE
- o_cnt  out  5  lowest bit index of the current W-bit beat
- o_cnt_done  out  1  last beat of the phase
- o_cnt0to3  out  1  o_cnt<4 while counting
- o_cnt12to31  out  1  o_cnt>=12 while counting
- o_ctrl_pc_en  out  1  RUN or TRAP
- o_ctrl_jump  out  1  latched take-branch
- o_ctrl_trap  out  1  state==TRAP
- o_rf_rs_en  out  1  read operands this cycle
- o_bufreg_hold  out  1  one-cycle hold pulse on leaving INIT to IDLE
- o_dbus_cyc  out  1  data bus request
- o_mdu_valid  out  1  MDU start request

Behaviour:
- Reset (synchronous, active-high): state=IDLE, o_cnt=0, o_cnt_done=0, pending_irq=0, stage_one_done=0, o_ctrl_jump=0, o_bufreg_hold=0, o_mdu_valid=0. All other outputs are combinational from these registers.
- Counter:
  - o_cnt += W on every cycle with o_cnt_en; wraps 5-bit modulo 32.
  - o_cnt_done is registered and asserted exactly during the beat where o_cnt==32-W, so each phase is exactly 32/W beats.
  - Leaving a phase returns o_cnt to 0 through the natural wrap, never by a force.
- IDLE:
  - On i_rf_ready: go to TRAP if i_e_op or pending_irq; else INIT if i_two_stage_op and !stage_one_done; else RUN.
  - Otherwise, if stage_one_done and a completion event fires, go to RUN. The completion events are: i_shift_op with i_sh_done; i_mem_op with i_dbus_ack; i_mdu_op with i_mdu_ready when MDU=1.
- INIT:
  - Sets stage_one_done=1.
  - o_ctrl_jump is loaded with i_take_branch every INIT cycle.
  - On o_cnt_done: go to TRAP if (i_mem_op & i_mem_misalign) or (i_take_branch & i_ctrl_misalign). Else go to IDLE with o_bufreg_hold pulsed 1 cycle if i_mem_op, i_shift_op or (MDU & i_mdu_op). Else go to RUN.
- RUN: clears stage_one_done; on o_cnt_done go to IDLE.
- TRAP: clears pending_irq; on o_cnt_done go to IDLE.
- o_ctrl_jump is forced to 0 whenever state==IDLE.
- pending_irq:
  - Set by i_new_irq.
  - If i_new_irq and the TRAP clear happen in the same cycle, the set wins.
  - A pending irq is never taken mid-instruction; it is taken only at the next IDLE with i_rf_ready.
- o_rf_rs_en = i_two_stage_op ? o_init : o_ctrl_pc_en.
- o_dbus_cyc:
  - Equals IDLE & stage_one_done & i_mem_op & !i_mem_misalign.
  - Held until i_dbus_ack; ack without a pending cycle is ignored.
- o_mdu_valid = IDLE & stage_one_done & i_mdu_op & MDU.
- Reset asserted mid-phase aborts immediately to IDLE with o_cnt=0; no partial trap is recorded.

Decomposition:
- Shared package/header (serv_params.vh): state encodings IDLE=0, INIT=1, RUN=2, TRAP=3; a localparam CNT_LAST=32-W derived from W.
- One natural sub-module, serv_cnt_w: the W-stepped counter producing o_cnt, o_cnt_done, o_cnt0to3 and o_cnt12to31.

Test Plan:
- W=1 add (i_rf_ready, no other flags) -> RUN for 32 cycles, o_cnt_done on cycle 32 with o_cnt=31, then IDLE with o_cnt=0.
- W=4 beq taken (two_stage, i_take_branch=1) -> INIT for 8 beats, o_ctrl_jump=1, RUN for 8 beats, o_ctrl_jump cleared in IDLE.
- W=1 load, address aligned -> INIT 32, o_bufreg_hold pulse, IDLE with o_dbus_cyc=1 until i_dbus_ack after 3 cycles, then RUN 32.
- W=2 load with i_mem_misalign=1 -> INIT 16 beats, then TRAP 16 beats, o_dbus_cyc never asserted.
- i_new_irq during RUN -> instruction completes; the next i_rf_ready enters TRAP; pending_irq clears; a simultaneous new irq on the clear cycle stays pending.
- MDU=1, W=8 div -> INIT 4 beats, IDLE with o_mdu_valid=1, i_mdu_ready -> RUN 4 beats. The same stimulus with MDU=0 -> o_mdu_valid stays 0 and no INIT->IDLE hold is taken for MDU.
